// File: rtl/crc_tx_pkg.sv
// crc_tx_pkg: shared CRC-32 constants, reflection helper and transmitter state enum
package crc_tx_pkg;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_XOROUT_DEF = 32'hFFFF_FFFF;
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction
  localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);
  typedef enum logic {ST_DATA, ST_CRC} state_t;
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational reflected CRC-32 update by one byte
//   crc      in  32  current CRC register
//   data     in  8   byte to absorb, LSB first
//   crc_next out 32  updated CRC register
module crc32_d8
  import crc_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  always_comb begin
    crc_next = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) crc_next = crc_next[0] ? (crc_next >> 1) ^ CRC_POLY_REFL : crc_next >> 1;
  end
endmodule

// File: rtl/crc32_append_tx.sv
// crc32_append_tx: byte-stream pass-through that appends the frame CRC-32 (LSB byte first)
//   clk, rst_n                      clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last   upstream payload bytes
//   m_valid/m_ready/m_data/m_last   downstream payload + 4 CRC bytes, m_last on final CRC byte
//   crc_value                       CRC of the last completed frame
//   frame_count                     completed frames, wrapping
module crc32_append_tx
  import crc_tx_pkg::*;
#(
  parameter logic [31:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [31:0] CRC_XOROUT = CRC_XOROUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic [31:0] crc_value,
  output logic [15:0] frame_count
);
  state_t state;
  logic [1:0] idx;
  logic [31:0] crc, crc_next, crc_out;
  logic slot_free;
  crc32_d8 u_crc (.crc(crc), .data(s_data), .crc_next(crc_next));
  assign slot_free = !m_valid || m_ready;
  assign s_ready = rst_n && state == ST_DATA && slot_free;
  assign crc_out = crc ^ CRC_XOROUT;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_DATA;
      idx <= 2'd0;
      crc <= CRC_INIT;
      m_valid <= 1'b0;
      m_data <= 8'h00;
      m_last <= 1'b0;
      crc_value <= 32'h0;
      frame_count <= 16'h0;
    end else if (state == ST_DATA) begin
      if (s_valid && s_ready) begin
        m_data <= s_data;
        m_valid <= 1'b1;
        m_last <= 1'b0;
        crc <= crc_next;
        if (s_last) begin
          state <= ST_CRC;
          idx <= 2'd0;
        end
      end else if (m_ready) m_valid <= 1'b0;
    end else if (slot_free) begin
      m_data <= 8'(crc_out >> {idx, 3'b000});
      m_valid <= 1'b1;
      m_last <= idx == 2'd3;
      idx <= idx + 2'd1;
      if (idx == 2'd3) begin
        crc_value <= crc_out;
        crc <= CRC_INIT;
        frame_count <= frame_count + 16'd1;
        state <= ST_DATA;
      end
    end
  end
endmodule

// File: tb/tb_crc32_append_tx.sv
// tb_crc32_append_tx: directed self-checking bench for crc32_append_tx
module tb_crc32_append_tx;
  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic s_ready, m_valid, m_last;
  logic [7:0] m_data;
  logic [31:0] crc_value;
  logic [15:0] frame_count;
  int vectors = 0, errors = 0;
  logic [7:0] tx[$];
  logic tl[$];
  logic [7:0] rx[$];
  logic rxl[$];
  int rxc[$];
  always #5 clk = ~clk;
  crc32_append_tx dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .crc_value(crc_value), .frame_count(frame_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) begin
      tx.push_back(s[i]);
      tl.push_back(i == s.len() - 1);
    end
  endtask
  task automatic load_byte(input logic [7:0] b);
    tx.push_back(b);
    tl.push_back(1'b1);
  endtask
  // mode 0: m_ready always 1; 1: alternating; 2: two of three cycles
  task automatic xfer(input int mode, input int stop_at, input int nframes);
    int ptr, nl;
    logic held;
    logic [7:0] hd;
    logic hl;
    ptr = 0; nl = 0; held = 1'b0; hd = 8'h00; hl = 1'b0;
    rx.delete(); rxl.delete(); rxc.delete();
    for (int cyc = 0; cyc < 2000 && nl < nframes && (stop_at == 0 || rx.size() < stop_at); cyc++) begin
      @(negedge clk);
      m_ready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'(cyc % 3 != 0);
      s_valid = ptr < tx.size();
      s_data = ptr < tx.size() ? tx[ptr] : 8'h00;
      s_last = ptr < tx.size() ? tl[ptr] : 1'b0;
      #1;
      if (held) begin
        chk("stall_data", {24'h0, m_data}, {24'h0, hd});
        chk("stall_last", {31'h0, m_last}, {31'h0, hl});
      end
      held = m_valid && !m_ready;
      hd = m_data;
      hl = m_last;
      if (held) chk("stall_s_ready", {31'h0, s_ready}, 32'h0);
      if (s_valid && s_ready) ptr++;
      if (m_valid && m_ready) begin
        rx.push_back(m_data);
        rxl.push_back(m_last);
        rxc.push_back(cyc);
        nl += int'(m_last);
      end
    end
    if (stop_at == 0) chk("frames_done", nl, nframes);
    s_valid = 1'b0;
    s_last = 1'b0;
    m_ready = 1'b1;
  endtask
  task automatic check_frame(input string tag, input int tb, input int rb, input int n, input logic [31:0] crc);
    for (int i = 0; i < n + 4; i++) begin
      chk({tag, "_data"}, {24'h0, rx[rb+i]}, {24'h0, i < n ? tx[tb+i] : crc[8*(i-n) +: 8]});
      chk({tag, "_last"}, {31'h0, rxl[rb+i]}, {31'h0, i == n + 3});
    end
  endtask
  initial begin
    s_valid = 1'b1;
    s_data = 8'hA5;
    @(negedge clk);
    @(negedge clk);
    chk("rst_m_valid", {31'h0, m_valid}, 32'h0);
    chk("rst_m_data", {24'h0, m_data}, 32'h0);
    chk("rst_m_last", {31'h0, m_last}, 32'h0);
    chk("rst_crc_value", crc_value, 32'h0);
    chk("rst_frame_count", {16'h0, frame_count}, 32'h0);
    chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
    s_valid = 1'b0;
    rst_n = 1'b1;
    tx.delete(); tl.delete();
    load("123456789");
    xfer(0, 0, 1);
    chk("t1_beats", rx.size(), 13);
    check_frame("t1", 0, 0, 9, 32'hCBF4_3926);
    @(negedge clk);
    chk("t1_crc_value", crc_value, 32'hCBF4_3926);
    chk("t1_frame_count", {16'h0, frame_count}, 32'd1);
    tx.delete(); tl.delete();
    load_byte(8'h00);
    xfer(0, 0, 1);
    chk("t2_beats", rx.size(), 5);
    check_frame("t2", 0, 0, 1, 32'hD202_EF8D);
    @(negedge clk);
    chk("t2_idle_valid", {31'h0, m_valid}, 32'h0);
    chk("t2_crc_value", crc_value, 32'hD202_EF8D);
    chk("t2_frame_count", {16'h0, frame_count}, 32'd2);
    tx.delete(); tl.delete();
    load("abc");
    xfer(1, 0, 1);
    chk("t3_beats", rx.size(), 7);
    check_frame("t3", 0, 0, 3, 32'h3524_41C2);
    tx.delete(); tl.delete();
    load_byte(8'hFF);
    xfer(2, 0, 1);
    chk("t4_beats", rx.size(), 5);
    check_frame("t4", 0, 0, 1, 32'hFF00_0000);
    @(negedge clk);
    chk("t4_frame_count", {16'h0, frame_count}, 32'd4);
    tx.delete(); tl.delete();
    load("a");
    load("123456789");
    xfer(0, 0, 2);
    chk("t5_beats", rx.size(), 18);
    check_frame("t5a", 0, 0, 1, 32'hE8B7_BE43);
    check_frame("t5b", 1, 5, 9, 32'hCBF4_3926);
    chk("t5_no_gap", rxc[5] - rxc[4], 1);
    @(negedge clk);
    chk("t5_frame_count", {16'h0, frame_count}, 32'd6);
    tx.delete(); tl.delete();
    load("123456789");
    xfer(0, 11, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_s_ready", {31'h0, s_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_m_valid", {31'h0, m_valid}, 32'h0);
    chk("t6_frame_count", {16'h0, frame_count}, 32'h0);
    chk("t6_crc_value", crc_value, 32'h0);
    xfer(0, 0, 1);
    chk("t6_beats", rx.size(), 13);
    check_frame("t6", 0, 0, 9, 32'hCBF4_3926);
    @(negedge clk);
    chk("t6_crc_after", crc_value, 32'hCBF4_3926);
    chk("t6_count_after", {16'h0, frame_count}, 32'd1);
    force dut.frame_count = 16'hFFFF;
    @(negedge clk);
    release dut.frame_count;
    #1;
    chk("t7_preload", {16'h0, frame_count}, 32'h0000_FFFF);
    tx.delete(); tl.delete();
    load_byte(8'h00);
    xfer(0, 0, 1);
    @(negedge clk);
    chk("t7_wrap", {16'h0, frame_count}, 32'h0);
    chk("t7_crc_value", crc_value, 32'hD202_EF8D);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/crc32_append_tx.md
CRC32_APPEND_TX -- requirements
Module: crc32_append_tx

Interface
REQ-001 Parameter: CRC_INIT, 32'hFFFF_FFFF, initial CRC register value loaded at the start of each frame.
REQ-002 Parameter: CRC_XOROUT, 32'hFFFF_FFFF, value XORed with the CRC register to form the transmitted CRC.
REQ-003 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-005 Port: s_valid  input  1  upstream byte valid.
REQ-006 Port: s_ready  output  1  upstream byte accepted when s_valid && s_ready.
REQ-007 Port: s_data  input  8  payload byte.
REQ-008 Port: s_last  input  1  marks the final payload byte of a frame.
REQ-009 Port: m_valid  output  1  downstream byte valid.
REQ-010 Port: m_ready  input  1  downstream accept.
REQ-011 Port: m_data  output  8  payload or CRC byte.
REQ-012 Port: m_last  output  1  high only on the final CRC byte of a frame.
REQ-013 Port: crc_value  output  32  final CRC (after XOROUT) of the last completed frame.
REQ-014 Port: frame_count  output  16  number of completed frames, wrapping.

Function
REQ-015 CRC: CRC-32 (poly 32'h04C1_1DB7), reflected input and output, INIT/XOROUT per parameters; computed over payload bytes only.
REQ-016 States: DATA (pass payload), CRC (emit 4 CRC bytes, index 0..3).
REQ-017 Output stage: one register; m_data/m_last/m_valid update only when !m_valid || m_ready (slot free).
REQ-018 DATA: s_ready = slot free; on accept, m_data <= s_data, m_valid <= 1, m_last <= 0, crc <= next(crc, s_data); latency 1 cycle.
REQ-019 DATA, accept with s_last=1: transition to CRC, index 0; CRC register holds the final value including that byte.
REQ-020 CRC: s_ready = 0; each time the slot is free, emit byte [index] of (crc ^ CRC_XOROUT), LSB byte first; index increments.
REQ-021 CRC, emitting index 3: m_last <= 1; crc_value <= final CRC; crc <= CRC_INIT; frame_count <= frame_count+1 (16'hFFFF wraps to 0); return to DATA.
REQ-022 Back-to-back frames: the first byte of the next frame is accepted in the cycle after the index-3 byte is loaded into the output register, provided the slot is free.
REQ-023 Backpressure: while m_valid && !m_ready, m_data and m_last are held stable and no input is accepted.
REQ-024 Zero-length frames cannot occur; every frame carries at least one payload byte.
REQ-025 When m_valid = 0, m_data and m_last are don't-care to consumers but are driven deterministically (held at their last values).

Reset
REQ-026 While rst_n = 0 at a clock edge: state DATA, crc = CRC_INIT, m_valid = 0, m_data = 0, m_last = 0, crc_value = 0, frame_count = 0.
REQ-027 s_ready is 0 whenever rst_n = 0.
REQ-028 Reset mid-frame or mid-CRC discards the partial frame; no CRC is emitted and frame_count is unchanged from 0.

Structure
REQ-029 Shared package crc_tx_pkg holds the polynomial constant, default INIT/XOROUT, and the state enum.
REQ-030 Sub-module crc32_d8 holds the combinational next-state function (32-bit CRC in, 8-bit data in, 32-bit CRC out, reflected); no other sub-modules.

Verification
REQ-031 Send "123456789" (9 bytes, last on '9'), m_ready=1 -> output is 9 payload bytes then 26 39 F4 CB with m_last on CB; crc_value=32'hCBF4_3926; frame_count=1.
REQ-032 Single byte 8'h00 -> CRC bytes 8D EF 02 D2 (CRC 32'hD202_EF8D); total 5 output beats.
REQ-033 Random m_ready (50%) with 100 random frames of 1-64 bytes -> m_data stable under stall; every frame matches cl_crc scoreboard model; no bytes lost or duplicated.
REQ-034 Two back-to-back frames, s_valid always 1, m_ready=1 -> no idle beat between the CB-equivalent m_last beat and the next frame's first byte.
REQ-035 Assert rst_n=0 for 1 cycle during CRC index 2 -> m_valid=0 next cycle; the following frame "123456789" again yields CBF43926; frame_count=1.
REQ-036 Preload 65535 completed frames (or force) then complete one more -> frame_count=0.
